// File: rtl/freq_range_if.sv
// Button-to-control bundle between the debouncer, freq_range_selector and the
// gate-time/display logic. state_dbg mirrors the press FSM for checkers.
interface freq_range_if #(
  parameter int RANGE_W = 2
);
  logic               btn_in;
  logic [RANGE_W-1:0] range_sel;
  logic               range_changed;
  logic               hold;
  logic               long_press;
  logic [1:0]         state_dbg;

  // Handshake: there is no valid/ready here. btn_in is a level, range_sel and
  // hold are levels, and range_changed/long_press are single-cycle strobes with
  // no backpressure, so a sink must sample them every clock or lose them.
  modport master (
    output btn_in,
    input  range_sel,
    input  range_changed,
    input  hold,
    input  long_press,
    input  state_dbg
  );

  modport slave (
    input  btn_in,
    output range_sel,
    output range_changed,
    output hold,
    output long_press,
    output state_dbg
  );
endinterface

// File: rtl/freq_range_selector.sv
// Short press advances the measurement range with wrap-around; long press toggles display hold.
// Optional macro FREQ_RANGE_SYNC_EN adds a two-flop synchronizer on btn_in.
module freq_range_selector #(
  parameter int NUM_RANGES        = 4,
  parameter int LONG_PRESS_CYCLES = 50000000
) (
  input logic        clk,
  input logic        rst_n,
  freq_range_if.slave bus
);
  localparam int RANGE_W = $clog2(NUM_RANGES);
  localparam int CNT_W   = $clog2(LONG_PRESS_CYCLES);

  localparam logic [RANGE_W-1:0] RANGE_MAX = RANGE_W'(NUM_RANGES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(LONG_PRESS_CYCLES - 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PRESSED   = 2'd1;
  localparam logic [1:0] ST_LONG_HELD = 2'd2;

  logic btn_s;

`ifdef FREQ_RANGE_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = bus.btn_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign btn_s = sync2_q;
`else
  assign btn_s = bus.btn_in;
`endif

  // btn_prev_q is btn_s delayed one clock; reset to 0 so a button still held
  // across reset release reads as a fresh rise and starts a new press.
  logic               btn_prev_q, btn_prev_d;
  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RANGE_W-1:0] range_q, range_d;
  logic               hold_q, hold_d;
  logic               range_chg_q, range_chg_d;
  logic               long_q, long_d;

  logic rise;
  logic fall;
  logic short_press;

  assign rise = btn_s & ~btn_prev_q;
  assign fall = ~btn_s & btn_prev_q;

  always_comb begin
    btn_prev_d  = btn_s;
    state_d     = state_q;
    cnt_d       = cnt_q;
    range_d     = range_q;
    hold_d      = hold_q;
    range_chg_d = 1'b0;
    long_d      = 1'b0;
    short_press = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end
      end

      ST_PRESSED: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        // A release on the threshold edge is checked first, so it stays a short press.
        if (fall) begin
          short_press = 1'b1;
          state_d     = ST_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          hold_d  = ~hold_q;
          long_d  = 1'b1;
          state_d = ST_LONG_HELD;
        end
      end

      ST_LONG_HELD: begin
        if (fall) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (short_press && !hold_q) begin
      range_d     = (range_q == RANGE_MAX) ? '0 : range_q + 1'b1;
      range_chg_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev_q  <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      range_q     <= '0;
      hold_q      <= 1'b0;
      range_chg_q <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      btn_prev_q  <= btn_prev_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      range_q     <= range_d;
      hold_q      <= hold_d;
      range_chg_q <= range_chg_d;
      long_q      <= long_d;
    end
  end

  assign bus.range_sel     = range_q;
  assign bus.range_changed = range_chg_q;
  assign bus.hold          = hold_q;
  assign bus.long_press    = long_q;
  assign bus.state_dbg     = state_q;

endmodule

// File: tb/tb_freq_range_selector.sv
// Directed bench for freq_range_selector (NUM_RANGES=3, LONG_PRESS_CYCLES=8), valid
// with or without FREQ_RANGE_SYNC_EN. Expected pulses carry their expected cycle.
module tb_freq_range_selector;
  localparam int NR  = 3;
  localparam int LPC = 8;
  localparam int RW  = 2;
`ifdef FREQ_RANGE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  // Expected pulse word: {cycle[15:0], is_long, range_sel, hold}
  localparam int EW = 16 + 1 + RW + 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  freq_range_if #(.RANGE_W(RW)) bus ();

  freq_range_selector #(
    .NUM_RANGES       (NR),
    .LONG_PRESS_CYCLES(LPC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // ---------------- model / scoreboard ----------------
  logic [RW-1:0] m_range = '0;
  logic          m_hold  = 1'b0;
  logic [EW-1:0] exp_q[$];
  int            checks  = 0;
  int            errors  = 0;

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_level(input string name);
    check_eq({name, "_range_sel"}, int'(bus.range_sel), int'(m_range));
    check_eq({name, "_hold"}, int'(bus.hold), int'(m_hold));
  endtask

  task automatic check_all_zero(input string name);
    check_eq({name, "_range_sel"}, int'(bus.range_sel), 0);
    check_eq({name, "_hold"}, int'(bus.hold), 0);
    check_eq({name, "_range_changed"}, int'(bus.range_changed), 0);
    check_eq({name, "_long_press"}, int'(bus.long_press), 0);
  endtask

  // Monitor: every cycle with a pulse must match the head of the expected queue.
  always @(negedge clk) begin
    logic [EW-1:0] act;
    logic [EW-1:0] exp;
    if (bus.range_changed || bus.long_press) begin
      act = {16'(cyc), bus.long_press, bus.range_sel, bus.hold};
      checks++;
      if (bus.range_changed && bus.long_press) begin
        errors++;
        $display("FAIL pulse_both: range_changed and long_press high together at cycle %0d", cyc);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected: got cyc=%0d long=%0b range=%0d hold=%0b, none expected",
                 cyc, bus.long_press, bus.range_sel, bus.hold);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL pulse: got cyc=%0d long=%0b range=%0d hold=%0b expected cyc=%0d long=%0b range=%0d hold=%0b",
                   act[EW-1 -: 16], act[RW+1], act[RW:1], act[0],
                   exp[EW-1 -: 16], exp[RW+1], exp[RW:1], exp[0]);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  // The driver always sits 1 time unit after a rising edge.
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the button for h sampled edges, then release for gap cycles.
  task automatic press(input int h, input int gap, input string name);
    int p;
    p = cyc;
    if (h <= LPC) begin
      if (!m_hold) begin
        m_range = (m_range == RW'(NR - 1)) ? '0 : m_range + 1'b1;
        exp_q.push_back({16'(p + h + 1 + LAT), 1'b0, m_range, m_hold});
      end
    end else begin
      m_hold = ~m_hold;
      exp_q.push_back({16'(p + 1 + LAT + LPC), 1'b1, m_range, m_hold});
    end
    bus.btn_in = 1'b1;
    wait_cycles(h);
    bus.btn_in = 1'b0;
    wait_cycles(gap);
    if (gap >= LAT + 2) check_level(name);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    bus.btn_in = 1'b0;

    // Reset with btn toggling; outputs must clear before any clock edge.
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_async");
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      bus.btn_in = ~bus.btn_in;
      #5;
    end
    bus.btn_in = 1'b0;
    check_all_zero("reset_held");
    rst_n = 1'b1;
    wait_cycles(4);
    check_level("after_reset");

    // Wrap-around: 1,2,0,1
    for (int i = 0; i < 4; i++) press(3, LAT + 3, "wrap");

    // Long press sets hold, range unchanged
    press(12, LAT + 3, "long_on");

    // Hold masks short presses
    press(3, LAT + 3, "masked_a");
    press(3, LAT + 3, "masked_b");

    // Second long press clears hold
    press(12, LAT + 3, "long_off");

    // Release on the threshold edge is short
    press(LPC, LAT + 3, "thresh_short");

    // Back-to-back single-cycle presses, every 2 cycles
    press(1, 1, "b2b_a");
    press(1, LAT + 3, "b2b_b");

    // Release one cycle after threshold is long
    press(LPC + 1, LAT + 3, "thresh_long");

    // Reset mid-press: discard, then time a new press from reset release
    bus.btn_in = 1'b1;
    wait_cycles(5);
    rst_n = 1'b0;
    m_range = '0;
    m_hold  = 1'b0;
    #1 check_all_zero("reset_mid_press");
    wait_cycles(3);
    r = cyc;
    m_hold = 1'b1;
    exp_q.push_back({16'(r + 1 + LAT + LPC), 1'b1, m_range, m_hold});
    rst_n = 1'b1;
    wait_cycles(10);
    bus.btn_in = 1'b0;
    wait_cycles(LAT + 3);
    check_level("after_mid_reset");

    // Second long press clears hold, then a short press advances again
    press(12, LAT + 3, "post_reset_long");
    press(2, LAT + 3, "post_reset_short");

    wait_cycles(10);
    check_eq("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
